// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions.
//   RESET_PC / EXC_VECTOR : default fetch addresses after reset and on exception entry
//   NOP                   : instruction register contents while nothing has been fetched
//   ST_*                  : fetch FSM state encoding
package cpu_pkg;

   localparam logic [31:0] RESET_PC   = 32'h0040_0000;
   localparam logic [31:0] EXC_VECTOR = 32'h0040_0004;
   localparam logic [31:0] NOP        = 32'h0000_0000;

   localparam logic [1:0] ST_START = 2'd0;
   localparam logic [1:0] ST_FETCH = 2'd1;
   localparam logic [1:0] ST_HOLD  = 2'd2;
   localparam logic [1:0] ST_KILL  = 2'd3;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction memory request bus.
//   imem_req   : fetch request, held with a stable imem_addr until imem_ready
//   imem_addr  : word address being fetched
//   imem_ready : one-cycle completion pulse
//   imem_rdata : instruction word, valid with imem_ready
// master = fetch unit, slave = instruction memory.
interface instr_fetch_unit_if;

   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;

   modport master (output imem_req, imem_addr, input imem_ready, imem_rdata);
   modport slave  (input imem_req, imem_addr, output imem_ready, imem_rdata);

endinterface

// File: rtl/pc_next_mux.sv
// Next-PC selection for the fetch unit (purely combinational).
//   pc, pc_plus4       : current PC and its 32-bit wrapping successor
//   flush              : exception entry, overrides everything
//   take               : the held instruction is being acknowledged this cycle
//   redirect_valid/pc  : control-flow target supplied with the acknowledge
//   next_pc            : PC to load on the next edge (pc itself when nothing happens)
//   misaligned         : taken redirect whose target is not word aligned
module pc_next_mux
   import cpu_pkg::*;
#(
   parameter logic [31:0] EXC_VECTOR_PC = cpu_pkg::EXC_VECTOR
) (
   input  logic [31:0] pc,
   input  logic        flush,
   input  logic        take,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic [31:0] pc_plus4,
   output logic [31:0] next_pc,
   output logic        misaligned
);

   assign pc_plus4 = pc + 32'd4;

   always_comb begin
      next_pc    = pc;
      misaligned = 1'b0;
      if (flush) begin
         next_pc = EXC_VECTOR_PC;
      end else if (take) begin
         if (!redirect_valid) begin
            next_pc = pc_plus4;
         end else if (redirect_pc[1:0] != 2'b00) begin
            // bad target traps to the exception vector instead of fetching garbage
            next_pc    = EXC_VECTOR_PC;
            misaligned = 1'b1;
         end else begin
            next_pc = redirect_pc;
         end
      end
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches one word at a time over the
// imem bus and holds it in the instruction register until the core acks it.
//   clk, rst       : clock, asynchronous active-high reset
//   imem           : instruction memory bus (master side)
//   instr          : held instruction word for the decoder
//   instr_valid    : instr/pc describe a live instruction
//   instr_ack      : core consumes instr this cycle
//   redirect_valid : with instr_ack, continue at redirect_pc instead of pc+4
//   redirect_pc    : control-flow target
//   flush_valid    : exception entry, any cycle, highest priority
//   pc, pc_plus4   : address of instr and its successor
//   pc_err         : one-cycle pulse after a misaligned redirect
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC   = cpu_pkg::RESET_PC,
   parameter logic [31:0] EXC_VECTOR = cpu_pkg::EXC_VECTOR
) (
   input  logic                       clk,
   input  logic                       rst,
   instr_fetch_unit_if.master         imem,
   output logic [31:0]                instr,
   output logic                       instr_valid,
   input  logic                       instr_ack,
   input  logic                       redirect_valid,
   input  logic [31:0]                redirect_pc,
   input  logic                       flush_valid,
   output logic [31:0]                pc,
   output logic [31:0]                pc_plus4,
   output logic                       pc_err
);
   import cpu_pkg::*;

   logic [1:0]  state, state_nxt;
   logic [31:0] pc_nxt;
   logic [31:0] kill_addr;
   logic        take;
   logic        misaligned;

   assign take = (state == ST_HOLD) && instr_ack;

   pc_next_mux #(.EXC_VECTOR_PC(EXC_VECTOR)) u_pc_next_mux (
      .pc             (pc),
      .flush          (flush_valid),
      .take           (take),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .pc_plus4       (pc_plus4),
      .next_pc        (pc_nxt),
      .misaligned     (misaligned)
   );

   // A flushed request keeps presenting its original address until the
   // memory completes it, even though pc has already moved to the vector.
   assign imem.imem_req  = (state == ST_FETCH) || (state == ST_KILL);
   assign imem.imem_addr = (state == ST_KILL) ? kill_addr : pc;

   always_comb begin
      state_nxt = ST_START;
      case (state)
         ST_START: state_nxt = ST_FETCH;
         ST_FETCH: begin
            if (imem.imem_ready) state_nxt = flush_valid ? ST_FETCH : ST_HOLD;
            else                 state_nxt = flush_valid ? ST_KILL  : ST_FETCH;
         end
         ST_HOLD:  state_nxt = (flush_valid || instr_ack) ? ST_FETCH : ST_HOLD;
         ST_KILL:  state_nxt = imem.imem_ready ? ST_FETCH : ST_KILL;
         default:  state_nxt = ST_START;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_START;
         pc          <= RESET_PC;
         kill_addr   <= RESET_PC;
         instr       <= NOP;
         instr_valid <= 1'b0;
         pc_err      <= 1'b0;
      end else begin
         state  <= state_nxt;
         pc     <= pc_nxt;
         pc_err <= misaligned;
         if (state == ST_FETCH && flush_valid && !imem.imem_ready)
            kill_addr <= pc;
         if (state == ST_FETCH && imem.imem_ready && !flush_valid)
            instr <= imem.imem_rdata;
         if (flush_valid)
            instr_valid <= 1'b0;
         else if (state == ST_FETCH && imem.imem_ready)
            instr_valid <= 1'b1;
         else if (take)
            instr_valid <= 1'b0;
      end
   end

endmodule
